// File: rtl/reg_bank_pkg.sv
// Types and constants shared by the Banco A register bank, its control unit
// and the access arbiter in front of it.
package reg_bank_pkg;

    localparam int BANK_ADDR_W = 4;
    localparam int BANK_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_picker.sv
// Combinational round-robin selector: first asserted request found scanning
// upward from the position just after the last winner, wrapping around.
module rr_picker
    import reg_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] winner,
    output logic [NREQ-1:0]  onehot
);

    // Scan last+1 .. last+NREQ (mod NREQ) and keep the first hit.
    always_comb begin
        logic [IDX_W-1:0] idx_s;
        logic             hit_s;
        any    = 1'b0;
        winner = '0;
        onehot = '0;
        idx_s  = '0;
        hit_s  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s  = IDX_W'((int'(last) + k) % NREQ);
            hit_s  = !any && req[idx_s];
            winner = hit_s ? idx_s : winner;
            any    = any | req[idx_s];
        end
        if (any) begin
            onehot[winner] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares the single Banco A access port among NREQ requesters: round-robin
// grant, one-cycle bank strobe, one-cycle done pulse with read data.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = BANK_ADDR_W,
    parameter int DATA_W = BANK_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        wr,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [DATA_W-1:0]      rdata,
    output logic                   bank_we,
    output logic                   bank_re,
    output logic [ADDR_W-1:0]      bank_addr,
    output logic [DATA_W-1:0]      bank_wdata,
    input  logic [DATA_W-1:0]      bank_rdata
);

    localparam int               IDX_W    = idx_w(NREQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                op_q, op_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                bank_we_q, bank_we_d;
    logic                bank_re_q, bank_re_d;
    logic [ADDR_W-1:0]   bank_addr_q, bank_addr_d;
    logic [DATA_W-1:0]   bank_wdata_q, bank_wdata_d;

    logic                pick_any_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [NREQ-1:0]     pick_onehot_s;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .last   (last_q),
        .any    (pick_any_s),
        .winner (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    // Next-state and next-output logic; strobes and done default low so each is a single-cycle pulse.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        op_d         = op_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        rdata_d      = rdata_q;
        bank_we_d    = 1'b0;
        bank_re_d    = 1'b0;
        bank_addr_d  = bank_addr_q;
        bank_wdata_d = bank_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d      = ACCESS;
                    last_d       = pick_idx_s;
                    op_d         = wr[pick_idx_s];
                    gnt_d        = pick_onehot_s;
                    bank_we_d    = wr[pick_idx_s];
                    bank_re_d    = !wr[pick_idx_s];
                    bank_addr_d  = addr[pick_idx_s*ADDR_W +: ADDR_W];
                    bank_wdata_d = wdata[pick_idx_s*DATA_W +: DATA_W];
                end else begin
                    gnt_d = '0;
                end
            end
            ACCESS: begin
                if (op_q) begin
                    state_d = RESP;
                    done_d  = gnt_q;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Bank returns data the cycle after the read strobe.
                rdata_d = bank_rdata;
                state_d = RESP;
                done_d  = gnt_q;
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, pointer, latched request and all output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= LAST_RST;
            op_q         <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            bank_we_q    <= 1'b0;
            bank_re_q    <= 1'b0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            op_q         <= op_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            bank_we_q    <= bank_we_d;
            bank_re_q    <= bank_re_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign bank_we    = bank_we_q;
    assign bank_re    = bank_re_q;
    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: transaction-level model, per-cycle
// compare, bank emulation and directed scenarios with literal expectations.
module tb_reg_bank_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic                   clk   = 1'b0;
    logic                   rst   = 1'b1;
    logic [NREQ-1:0]        req   = '0;
    logic [NREQ-1:0]        wr    = '0;
    logic [NREQ*ADDR_W-1:0] addr  = '0;
    logic [NREQ*DATA_W-1:0] wdata = '0;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   bank_we;
    logic                   bank_re;
    logic [ADDR_W-1:0]      bank_addr;
    logic [DATA_W-1:0]      bank_wdata;
    logic [DATA_W-1:0]      bank_rdata = '0;

    reg_bank_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .done       (done),
        .rdata      (rdata),
        .bank_we    (bank_we),
        .bank_re    (bank_re),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bank emulation (driven by the DUT strobes) and the model's own copy.
    logic [DATA_W-1:0] bank_mem [16];
    logic [DATA_W-1:0] mmem     [16];

    initial begin
        logic              s_we, s_re;
        logic [ADDR_W-1:0] s_a;
        logic [DATA_W-1:0] s_d;
        forever begin
            @(posedge clk);
            s_we = bank_we; s_re = bank_re; s_a = bank_addr; s_d = bank_wdata;
            #1;
            if (s_we === 1'b1) bank_mem[s_a] = s_d;
            if (s_re === 1'b1) bank_rdata = bank_mem[s_a];
        end
    end

    // Transaction-level model: a grant starts a transaction, the strobe is in
    // its first cycle, done arrives in cycle 2 (write) or 3 (read).
    logic [NREQ-1:0]   e_gnt   = '0;
    logic [NREQ-1:0]   e_done  = '0;
    logic [DATA_W-1:0] e_rdata = '0;
    logic              e_we    = 1'b0;
    logic              e_re    = 1'b0;
    logic [ADDR_W-1:0] e_addr  = '0;
    logic [DATA_W-1:0] e_wdata = '0;
    bit                busy    = 1'b0;
    int                t_in    = 0;
    int                len     = 0;
    int                cur_w   = 0;
    int                last_w  = NREQ - 1;
    logic              cur_wr  = 1'b0;
    logic [ADDR_W-1:0] cur_addr  = '0;
    logic [DATA_W-1:0] cur_wdata = '0;

    initial begin
        int w;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                busy = 1'b0; t_in = 0; last_w = NREQ - 1;
                e_gnt = '0; e_done = '0; e_rdata = '0; e_we = 1'b0; e_re = 1'b0;
                e_addr = '0; e_wdata = '0;
            end else begin
                e_done = '0; e_we = 1'b0; e_re = 1'b0;
                if (busy) begin
                    t_in = t_in + 1;
                    len  = cur_wr ? 2 : 3;
                    if (t_in == len) begin
                        e_done[cur_w] = 1'b1;
                        if (!cur_wr) e_rdata = mmem[cur_addr];
                    end else if (t_in > len) begin
                        busy  = 1'b0;
                        e_gnt = '0;
                    end
                end else begin
                    w = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        int i;
                        i = (last_w + k) % NREQ;
                        if (w < 0 && req[i] === 1'b1) w = i;
                    end
                    if (w >= 0) begin
                        busy = 1'b1; t_in = 1; cur_w = w; last_w = w;
                        cur_wr    = wr[w];
                        cur_addr  = addr[w*ADDR_W +: ADDR_W];
                        cur_wdata = wdata[w*DATA_W +: DATA_W];
                        e_gnt = '0; e_gnt[w] = 1'b1;
                        e_we = cur_wr; e_re = !cur_wr;
                        e_addr = cur_addr; e_wdata = cur_wdata;
                        if (cur_wr) mmem[cur_addr] = cur_wdata;
                    end
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("gnt", gnt, e_gnt);
            chk("done", done, e_done);
            chk("rdata", rdata, e_rdata);
            chk("bank_we", bank_we, e_we);
            chk("bank_re", bank_re, e_re);
            chk("bank_addr", bank_addr, e_addr);
            chk("bank_wdata", bank_wdata, e_wdata);
            chk("gnt_onehot0", ($countones(gnt) <= 1), 1);
        end
    end

    logic [NREQ-1:0] drop_mask = '1;
    int              done_log[$];

    // One cycle; requesters in drop_mask release req on their own done.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (done[i] === 1'b1) begin
                done_log.push_back(i);
                if (drop_mask[i]) req[i] = 1'b0;
            end
        end
    endtask

    task automatic collect(input int cnt, input int bound);
        int n;
        n = 0;
        while (done_log.size() < cnt && n < bound) begin
            step();
            n++;
        end
    endtask

    int ord3 [4] = '{0, 1, 2, 3};
    int ord4 [4] = '{3, 1, 3, 1};
    int ord6 [2] = '{0, 1};

    initial begin
        for (int i = 0; i < 16; i++) begin
            bank_mem[i] = 8'(i * 19 + 33);
            mmem[i]     = bank_mem[i];
        end
        bank_mem[7] = 8'h3C;
        mmem[7]     = 8'h3C;

        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {bank_we, bank_re}, 0);
        rst = 1'b0;
        step();

        // Write from requester 0.
        addr[0 +: 4] = 4'h3; wdata[0 +: 8] = 8'hA5; wr = 4'b0001; req = 4'b0001;
        step();
        chk("t1_we", bank_we, 1);
        chk("t1_addr", bank_addr, 4'h3);
        chk("t1_wdata", bank_wdata, 8'hA5);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_early_done", done, 0);
        step();
        chk("t1_done", done, 4'b0001);
        chk("t1_we_once", bank_we, 0);
        chk("t1_rdata", rdata, 0);
        step();
        chk("t1_done_once", done, 0);
        chk("t1_gnt_clr", gnt, 0);

        // Read of preloaded register 7 by requester 2.
        addr[8 +: 4] = 4'h7; wr = 4'b0000; req = 4'b0100;
        step();
        chk("t2_re", bank_re, 1);
        chk("t2_addr", bank_addr, 4'h7);
        step();
        chk("t2_re_once", bank_re, 0);
        chk("t2_early_done", done, 0);
        step();
        chk("t2_done", done, 4'b0100);
        chk("t2_rdata", rdata, 8'h3C);
        step();

        // Fresh pointer, all four request, each leaves on its own done.
        rst = 1'b1;
        step();
        rst = 1'b0;
        addr = {4'hB, 4'hA, 4'h9, 4'h8};
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        wr = 4'b0101;
        done_log.delete();
        req = 4'b1111;
        collect(4, 60);
        chk("t3_count", done_log.size(), 4);
        for (int k = 0; k < done_log.size() && k < 4; k++) chk("t3_order", done_log[k], ord3[k]);
        step(); step();

        // Requester 1 served, then 1 and 3 both hold req continuously.
        addr[4 +: 4] = 4'hC; addr[12 +: 4] = 4'hD;
        wdata[8 +: 8] = 8'h5E; wdata[24 +: 8] = 8'h7F;
        wr = 4'b1010;
        req = 4'b0010;
        done_log.delete();
        collect(1, 10);
        chk("t4_first", (done_log.size() == 1) ? done_log[0] : -1, 1);
        drop_mask = '0;
        done_log.delete();
        req = 4'b1010;
        collect(4, 60);
        req = '0;
        drop_mask = '1;
        chk("t4_count", done_log.size(), 4);
        for (int k = 0; k < done_log.size() && k < 4; k++) chk("t4_order", done_log[k], ord4[k]);
        repeat (6) step();

        // Read whose req and addr change in the ACCESS cycle.
        addr[4 +: 4] = 4'h3; wr = 4'b0000; req = 4'b0010;
        step();
        chk("t5_re", bank_re, 1);
        chk("t5_addr", bank_addr, 4'h3);
        req = 4'b0000; addr[4 +: 4] = 4'hF; wr[1] = 1'b1;
        step();
        step();
        chk("t5_done", done, 4'b0010);
        chk("t5_rdata", rdata, 8'hA5);
        repeat (3) step();

        // Reset during CAPTURE of a read by requester 0.
        addr[0 +: 4] = 4'h7; wr = 4'b0000; req = 4'b0001;
        step();
        step();
        chk("t6_in_capture", {bank_re, gnt}, {1'b0, 4'b0001});
        rst = 1'b1;
        req = '0;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_rdata", rdata, 0);
        chk("t6_rst_bank", {bank_we, bank_re, bank_addr, bank_wdata}, 0);
        step();
        chk("t6_no_done", done, 0);
        rst = 1'b0;
        step();
        chk("t6_no_done2", done, 0);
        addr[0 +: 4] = 4'h4; addr[4 +: 4] = 4'h5;
        wdata[0 +: 8] = 8'h9A; wdata[8 +: 8] = 8'hBC;
        wr = 4'b0011;
        done_log.delete();
        req = 4'b0011;
        collect(2, 30);
        chk("t6_count", done_log.size(), 2);
        for (int k = 0; k < done_log.size() && k < 2; k++) chk("t6_order", done_log[k], ord6[k]);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
